rv32i_memarbiter: RTL and testbench
===================================

Name: rv32i_memArbiter

Overview:
- Arbitrates the single-ported, word-addressed instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store).
- Sits between the pipeline stages and the memory interface. Grants one request per cycle and routes the registered read data back to the requester that issued it.
- Data accesses have priority. A starvation counter guarantees forward progress for fetch.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive data grants while a fetch waits before fetch is forced. Legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request
- if_addr  in  30  fetch word address [31:2]
- if_gnt  out  1  fetch request accepted this cycle
- if_rdata  out  32  fetch read data
- if_rvalid  out  1  if_rdata valid
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  store byte enables
- d_addr  in  30  data word address [31:2]
- d_wdata  in  32  store data
- d_gnt  out  1  data request accepted this cycle
- d_rdata  out  32  load read data
- d_rvalid  out  1  d_rdata valid (loads only)
- mem_req  out  1  request to memory
- mem_we  out  1  write strobe
- mem_be  out  4  byte enables
- mem_addr  out  30  word address
- mem_wdata  out  32  write data
- mem_ready  in  1  memory accepts request this cycle
- mem_rdata  in  32  read data, valid the cycle after acceptance (memory output is registered)

Behaviour:
- Acceptance: a request is accepted when mem_req && mem_ready. Exactly one of if_gnt/d_gnt is high in an accepting cycle; both are low otherwise.
- Requester rule: a requester holds req and its address/data stable until its gnt.
- FSM state ARB (reset state):
  - Winner is D if d_req && !(starve_cnt == STARVE_LIMIT && if_req); else IF if if_req; else none.
  - mem_req = if_req | d_req. mem_* fields are muxed from the winner.
  - If mem_req && !mem_ready, the winner is registered as owner and the FSM goes to HOLD.
- FSM state HOLD:
  - Owner is frozen; the mem_* fields come from the owner. Requests from the other port are ignored.
  - On mem_ready, the owner is granted and the FSM returns to ARB.
  - A newly arriving request never preempts the held owner.
- IF-selected fields: mem_we = 0, mem_be = 4'b1111, mem_wdata = 0.
- D-selected fields: mem_we = d_we, and mem_be/mem_wdata driven from d_be/d_wdata. mem_be = 4'b1111 for loads.
- Starvation counter (4-bit starve_cnt):
  - Increments on a d_gnt while if_req is high.
  - Clears on if_gnt, or in any cycle with if_req low.
  - Saturates at STARVE_LIMIT.
- Response tracking: registers resp_valid and resp_owner at acceptance.
  - resp_valid = 1 on any accepted read: all fetches, and data loads.
  - resp_valid = 0 on stores and in idle cycles.
- Responses (one cycle after acceptance):
  - if_rvalid = resp_valid && resp_owner == IF.
  - d_rvalid = resp_valid && resp_owner == D.
  - if_rdata and d_rdata are both driven directly by mem_rdata, with no extra latency.
- Pipelining: back-to-back accepts are allowed. The response for the request accepted in cycle N appears in N+1, while the request in N+1 may also be accepted.
- Simultaneous requests at cnt < LIMIT: D wins. At cnt == LIMIT: IF wins, and the counter then clears.
- Reset (asynchronous, active-low), including mid-HOLD or mid-response:
  - FSM goes to ARB; starve_cnt = 0; resp_valid = 0.
  - if_gnt, d_gnt, if_rvalid and d_rvalid are 0.
  - An in-flight response is dropped.
  - mem_* outputs stay combinational from inputs; mem_req is forced 0 while reset is asserted.

Test Plan:
- IF only, mem_ready = 1, if_addr = 0, 1, 2 on consecutive cycles -> if_gnt high every cycle. if_rvalid high one cycle later each time with mem_rdata passed through. d_* responses stay 0.
- if_req and d_req (load, addr 0x10) both high -> d_gnt first. d_rvalid next cycle. if_gnt the following cycle.
- d_req held continuously, if_req held, STARVE_LIMIT = 4 -> 4 d_gnts, then 1 if_gnt, then the counter restarts. Pattern repeats DDDDI.
- Store (d_we = 1, d_be = 4'b0011, wdata = 0xDEADBEEF) -> mem_we = 1 with mem_be/mem_wdata matching for one accepting cycle. No d_rvalid follows.
- Fetch presented with mem_ready = 0 for 3 cycles; d_req rises in cycle 2 -> fetch stays owner (HOLD) and is granted when mem_ready rises. Data is granted next.
- Reset asserted the cycle after a load is accepted -> d_rvalid stays 0, FSM in ARB, counter 0. After deassertion the first request is granted normally.

Source files
------------

// File: rtl/rv32i_memarbiter.sv
// rtl/rv32i_memarbiter.sv - IF/MEM arbiter for a single-ported word memory
// Data has priority; a starvation counter forces a fetch after STARVE_LIMIT data grants.
module rv32i_memarbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        if_req,
   input  logic [29:0] if_addr,
   output logic        if_gnt,
   output logic [31:0] if_rdata,
   output logic        if_rvalid,

   input  logic        d_req,
   input  logic        d_we,
   input  logic [3:0]  d_be,
   input  logic [29:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic [31:0] d_rdata,
   output logic        d_rvalid,

   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   typedef enum logic {
      ST_ARB  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t      state;
   state_t      state_nxt;
   logic        owner_d;
   logic        owner_d_nxt;
   logic [3:0]  starve_cnt;
   logic        resp_valid;
   logic        resp_owner_d;

   logic        starved;
   logic        arb_d;
   logic        sel_d;
   logic        accept;

   // Fetch wins a simultaneous request only once data has been granted LIMIT times in a row.
   assign starved = (starve_cnt == LIMIT) && if_req;
   assign arb_d   = d_req && !starved;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_ARB;
         owner_d <= 1'b0;
      end else begin
         state   <= state_nxt;
         owner_d <= owner_d_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      owner_d_nxt = owner_d;
      case (state)
         ST_ARB: begin
            if ((if_req || d_req) && !mem_ready) begin
               state_nxt   = ST_HOLD;
               owner_d_nxt = arb_d;
            end
         end
         ST_HOLD: begin
            if (mem_ready)
               state_nxt = ST_ARB;
         end
      endcase
   end

   // Outputs: in HOLD the frozen owner drives memory, otherwise the current winner.
   always_comb begin
      sel_d     = (state == ST_HOLD) ? owner_d : arb_d;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_be    = 4'b1111;
      mem_addr  = if_addr;
      mem_wdata = 32'h0;
      if (reset) begin
         if (state == ST_HOLD)
            mem_req = owner_d ? d_req : if_req;
         else
            mem_req = if_req || d_req;
      end
      if (sel_d) begin
         mem_we    = d_we;
         mem_be    = d_we ? d_be : 4'b1111;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end
      accept = mem_req && mem_ready;
      if_gnt = accept && !sel_d;
      d_gnt  = accept && sel_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= 4'd0;
      end else if (!if_req || if_gnt) begin
         starve_cnt <= 4'd0;
      end else if (d_gnt && (starve_cnt != LIMIT)) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   // Stores produce no response; every accepted read returns data the next cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         resp_valid   <= 1'b0;
         resp_owner_d <= 1'b0;
      end else begin
         resp_valid   <= accept && !(sel_d && d_we);
         resp_owner_d <= sel_d;
      end
   end

   assign if_rvalid = resp_valid && !resp_owner_d;
   assign d_rvalid  = resp_valid && resp_owner_d;
   assign if_rdata  = mem_rdata;
   assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_rv32i_memarbiter.sv
// tb/tb_rv32i_memarbiter.sv - randomized and directed check of rv32i_memarbiter
module tb_rv32i_memarbiter;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        if_req = 1'b0;
   logic [29:0] if_addr = '0;
   logic        if_gnt;
   logic [31:0] if_rdata;
   logic        if_rvalid;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [3:0]  d_be = '0;
   logic [29:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_gnt;
   logic [31:0] d_rdata;
   logic        d_rvalid;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;

   rv32i_memarbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rdata(if_rdata), .if_rvalid(if_rvalid),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference state: who holds the memory (0 none, 1 IF, 2 D), data-grant streak, pending responder.
   int hold_who = 0;
   int streak = 0;
   int resp_who = 0;
   int g;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(output int granted);
      int   win;
      logic acc;
      #3;
      if (hold_who != 0)                                win = hold_who;
      else if (d_req && !(streak == LIMIT && if_req))   win = 2;
      else if (if_req)                                  win = 1;
      else                                              win = 0;
      acc = (win != 0) && mem_ready;
      check_val("mem_req", mem_req, 32'(win != 0));
      check_val("if_gnt", if_gnt, 32'(acc && win == 1));
      check_val("d_gnt", d_gnt, 32'(acc && win == 2));
      check_val("if_rvalid", if_rvalid, 32'(resp_who == 1));
      check_val("d_rvalid", d_rvalid, 32'(resp_who == 2));
      if (resp_who == 1) check_val("if_rdata", if_rdata, mem_rdata);
      if (resp_who == 2) check_val("d_rdata", d_rdata, mem_rdata);
      if (win == 1) begin
         check_val("if_addr", 32'(mem_addr), 32'(if_addr));
         check_val("if_we", 32'(mem_we), 32'd0);
         check_val("if_be", 32'(mem_be), 32'hF);
         check_val("if_wdata", mem_wdata, 32'd0);
      end
      if (win == 2) begin
         check_val("d_addr", 32'(mem_addr), 32'(d_addr));
         check_val("d_we", 32'(mem_we), 32'(d_we));
         check_val("d_be", 32'(mem_be), d_we ? 32'(d_be) : 32'hF);
         if (d_we) check_val("d_wdata", mem_wdata, d_wdata);
      end
      @(posedge clk);
      #1;
      if (!if_req || (acc && win == 1))        streak = 0;
      else if (acc && win == 2 && streak < LIMIT) streak++;
      if (acc)            hold_who = 0;
      else if (win != 0)  hold_who = win;
      resp_who  = !acc ? 0 : (win == 1 ? 1 : (d_we ? 0 : 2));
      granted   = acc ? win : 0;
      mem_rdata = $urandom;
   endtask

   initial begin
      // Requests present during reset must not reach memory.
      if_req = 1'b1; d_req = 1'b1; mem_ready = 1'b1;
      #2;
      check_val("rst_mem_req", mem_req, 0);
      check_val("rst_if_gnt", if_gnt, 0);
      check_val("rst_d_gnt", d_gnt, 0);
      check_val("rst_rvalid", {if_rvalid, d_rvalid}, 0);
      if_req = 1'b0; d_req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;

      // Load accepted, then reset drops its response.
      d_req = 1'b1; d_we = 1'b0; d_addr = 30'h10; mem_ready = 1'b1;
      step(g);
      check_val("load_gnt", g, 2);
      if_req = 1'b1; d_req = 1'b0;
      reset = 1'b0;
      #2;
      check_val("midrst_d_rvalid", d_rvalid, 0);
      check_val("midrst_mem_req", mem_req, 0);
      check_val("midrst_gnt", {if_gnt, d_gnt}, 0);
      hold_who = 0; streak = 0; resp_who = 0;
      @(posedge clk); #1;
      reset = 1'b1;

      // Both ports saturated: DDDDI repeating.
      if_req = 1'b1; if_addr = 30'h0; d_req = 1'b1; d_we = 1'b0; d_addr = 30'h10;
      for (int i = 0; i < 3 * (LIMIT + 1); i++) begin
         step(g);
         check_val("starve_seq", g, (i % (LIMIT + 1) == LIMIT) ? 1 : 2);
         if (g == 1) if_addr = if_addr + 30'd1;
      end
      if_req = 1'b0; d_req = 1'b0;
      step(g);

      // Fetch stalled by memory keeps ownership against a late data request.
      if_req = 1'b1; if_addr = 30'h55; mem_ready = 1'b0;
      step(g); check_val("hold_c0", g, 0);
      step(g); check_val("hold_c1", g, 0);
      d_req = 1'b1; d_we = 1'b0; d_addr = 30'h99;
      step(g); check_val("hold_c2", g, 0);
      mem_ready = 1'b1;
      step(g); check_val("hold_if", g, 1);
      if_req = 1'b0;
      step(g); check_val("hold_then_d", g, 2);
      d_req = 1'b0;

      // Store: fields pass through, no response follows.
      d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'hDEADBEEF; d_addr = 30'h20;
      step(g); check_val("store_gnt", g, 2);
      d_req = 1'b0;
      step(g);

      // Random traffic; requesters hold until granted.
      for (int i = 0; i < 600; i++) begin
         if (if_req && g != 1) begin end
         else begin
            if_req  = ($urandom_range(0, 2) != 0);
            if_addr = 30'($urandom);
         end
         if (d_req && g != 2) begin end
         else begin
            d_req   = ($urandom_range(0, 2) != 0);
            d_we    = 1'($urandom_range(0, 1));
            d_be    = 4'($urandom);
            d_addr  = 30'($urandom);
            d_wdata = $urandom;
         end
         mem_ready = ($urandom_range(0, 3) != 0);
         step(g);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
